relay_clock_sequencer: RTL and testbench

- Parametrised successor to the 4-relay clock ring: an N-stage relay ring modelled as a Johnson (twisted-ring) sequence, advanced one stage every DWELL clocks to emulate relay switching delay.
- Adds proper run/stop, single-cycle stepping, power gating, clean stop at cycle boundary and a cycle counter.
- Drives `relay_clock` to the rest of the relay computer; sits at top level beside the front-panel switches.

---
 rtl/relay_clock_sequencer.sv | 156 +++++++++++++++
 tb/tb_relay_clock_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/relay_clock_sequencer.sv
// ============================================================================
// Module      : relay_clock_sequencer
// Description : N-stage Johnson relay ring stepped every DWELL clocks, with
//               run/stop, single-cycle stepping, power gating and cycle count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module relay_clock_sequencer #(
    parameter int NUM_PHASES = 4,
    parameter int DWELL      = 10,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  power,
    input  logic                  run_stop,
    input  logic                  single_step,
    output logic [NUM_PHASES-1:0] relays,
    output logic                  relay_clock,
    output logic                  running,
    output logic                  cycle_done,
    output logic [CNT_WIDTH-1:0]  cycle_count
);

    localparam int                 DWELL_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWELL_W-1:0] C_DWELL_LAST = DWELL_W'(DWELL - 1);

    typedef enum logic [2:0] {
        S_OFF     = 3'd0,
        S_IDLE    = 3'd1,
        S_RUN     = 3'd2,
        S_STEP    = 3'd3,
        S_HALTING = 3'd4
    } state_t;

    state_t                  r_state_q,       w_state_d;
    logic [NUM_PHASES-1:0]   r_relays_q,      w_relays_d;
    logic [DWELL_W-1:0]      r_dwell_q,       w_dwell_d;
    logic                    r_step_q;
    logic                    r_cycle_done_q,  w_cycle_done_d;
    logic [CNT_WIDTH-1:0]    r_cycle_count_q, w_cycle_count_d;

    logic                    w_active;
    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_step_edge;
    logic [NUM_PHASES-1:0]   w_ring_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state_q       <= S_OFF;
            r_relays_q      <= '0;
            r_dwell_q       <= '0;
            r_step_q        <= 1'b0;
            r_cycle_done_q  <= 1'b0;
            r_cycle_count_q <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_relays_q      <= w_relays_d;
            r_dwell_q       <= w_dwell_d;
            r_step_q        <= single_step;
            r_cycle_done_q  <= w_cycle_done_d;
            r_cycle_count_q <= w_cycle_count_d;
        end
    end

    always_comb begin
        w_active    = (r_state_q == S_RUN) || (r_state_q == S_STEP) ||
                      (r_state_q == S_HALTING);
        w_tick      = w_active && (r_dwell_q == C_DWELL_LAST);
        w_ring_next = {r_relays_q[NUM_PHASES-2:0], ~r_relays_q[NUM_PHASES-1]};
        w_wrap      = w_tick && (w_ring_next == '0);
        w_step_edge = single_step & ~r_step_q;

        w_state_d       = r_state_q;
        w_relays_d      = r_relays_q;
        w_dwell_d       = '0;
        w_cycle_done_d  = 1'b0;
        w_cycle_count_d = r_cycle_count_q;

        if (w_active) begin
            w_dwell_d = w_tick ? '0 : r_dwell_q + DWELL_W'(1);
            if (w_tick) begin
                w_relays_d = w_ring_next;
            end
            if (w_wrap) begin
                w_cycle_done_d  = 1'b1;
                w_cycle_count_d = r_cycle_count_q + CNT_WIDTH'(1);
            end
        end

        case (r_state_q)
            S_OFF: begin
                if (power) begin
                    w_state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (run_stop) begin
                    w_state_d = S_RUN;
                end else if (w_step_edge) begin
                    w_state_d = S_STEP;
                end
            end
            S_RUN: begin
                if (!run_stop) begin
                    // Already sitting at the boundary: stop without another step
                    if ((r_relays_q == '0) && (r_dwell_q == '0)) begin
                        w_state_d       = S_IDLE;
                        w_relays_d      = r_relays_q;
                        w_dwell_d       = '0;
                        w_cycle_done_d  = 1'b0;
                        w_cycle_count_d = r_cycle_count_q;
                    end else begin
                        w_state_d = S_HALTING;
                    end
                end
            end
            S_STEP: begin
                if (w_wrap) begin
                    w_state_d = S_IDLE;
                end
            end
            S_HALTING: begin
                if (run_stop) begin
                    w_state_d = S_RUN;
                end else if (w_wrap) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_OFF;
            end
        endcase

        // Power loss overrides everything, including a cycle completing this clock
        if (!power) begin
            w_state_d       = S_OFF;
            w_relays_d      = '0;
            w_dwell_d       = '0;
            w_cycle_done_d  = 1'b0;
            w_cycle_count_d = r_cycle_count_q;
        end
    end

    assign relays      = r_relays_q;
    assign relay_clock = r_relays_q[NUM_PHASES-2] & ~r_relays_q[NUM_PHASES-1];
    assign running     = (r_state_q == S_RUN) || (r_state_q == S_STEP) ||
                         (r_state_q == S_HALTING);
    assign cycle_done  = r_cycle_done_q;
    assign cycle_count = r_cycle_count_q;

endmodule

`default_nettype wire

// File: tb/tb_relay_clock_sequencer.sv
// ============================================================================
// Module      : tb_relay_clock_sequencer
// Description : Directed bench for relay_clock_sequencer (N=4, DWELL=2,
//               CNT_WIDTH=2) with a cycle_done-driven scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_relay_clock_sequencer;

    logic       clock;
    logic       reset;
    logic       power;
    logic       run_stop;
    logic       single_step;
    logic [3:0] relays;
    logic       relay_clock;
    logic       running;
    logic       cycle_done;
    logic [1:0] cycle_count;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rc_cnt   = 0;
    int         rc0;
    logic [1:0] exp_q[$];

    relay_clock_sequencer #(
        .NUM_PHASES (4),
        .DWELL      (2),
        .CNT_WIDTH  (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .power       (power),
        .run_stop    (run_stop),
        .single_step (single_step),
        .relays      (relays),
        .relay_clock (relay_clock),
        .running     (running),
        .cycle_done  (cycle_done),
        .cycle_count (cycle_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (relay_clock) rc_cnt <= rc_cnt + 1;
    end

    // Scoreboard monitor: every cycle_done pulse consumes one expected count
    always @(negedge clock) begin
        if (!reset && cycle_done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cycle_done_unexpected: got count %0d expected no pulse", cycle_count);
            end else begin
                check("cycle_count_on_done", 32'(cycle_count), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        power       = 1'b1;
        run_stop    = 1'b0;
        single_step = 1'b0;

        // Reset and power-up
        tick(3);
        check("rst_relays", 32'(relays), 32'h0);
        check("rst_relay_clock", 32'(relay_clock), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_cycle_done", 32'(cycle_done), 32'h0);
        check("rst_cycle_count", 32'(cycle_count), 32'h0);
        reset = 1'b0;
        tick(1);
        check("idle_running", 32'(running), 32'h0);
        tick(10);
        check("idle_relays_hold", 32'(relays), 32'h0);
        check("idle_running_hold", 32'(running), 32'h0);

        // Free run: three cycles
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        run_stop = 1'b1;
        rc0 = rc_cnt;
        tick(1);
        check("run_enter_running", 32'(running), 32'h1);
        check("run_enter_relays", 32'(relays), 32'h0);
        tick(1);
        check("run_latency_relays", 32'(relays), 32'h0);
        tick(1);
        check("run_first_step", 32'(relays), 32'h1);
        tick(4);
        check("run_0111", 32'(relays), 32'h7);
        check("run_relay_clock_hi", 32'(relay_clock), 32'h1);
        tick(10);
        check("run_wrap_relays", 32'(relays), 32'h0);
        check("run_wrap_done", 32'(cycle_done), 32'h1);
        check("run_relay_clock_width", 32'(rc_cnt - rc0), 32'd2);
        tick(32);
        check("run_third_wrap", 32'(cycle_count), 32'h3);

        // Stop mid-cycle at 0111
        exp_q.push_back(2'd0);
        tick(6);
        check("halt_at_0111", 32'(relays), 32'h7);
        run_stop = 1'b0;
        tick(2);
        check("halt_1111", 32'(relays), 32'hF);
        check("halt_running", 32'(running), 32'h1);
        tick(8);
        check("halt_end_relays", 32'(relays), 32'h0);
        check("halt_end_running", 32'(running), 32'h0);
        tick(6);
        check("halt_hold_relays", 32'(relays), 32'h0);
        check("halt_hold_running", 32'(running), 32'h0);

        // Single step, with an ignored mid-cycle edge
        exp_q.push_back(2'd1);
        rc0 = rc_cnt;
        single_step = 1'b1;
        tick(1);
        check("step_running", 32'(running), 32'h1);
        tick(2);
        single_step = 1'b0;
        check("step_first", 32'(relays), 32'h1);
        tick(4);
        single_step = 1'b1;
        tick(2);
        single_step = 1'b0;
        tick(8);
        check("step_end_relays", 32'(relays), 32'h0);
        check("step_end_running", 32'(running), 32'h0);
        check("step_relay_clock_pulses", 32'(rc_cnt - rc0), 32'd2);
        tick(6);
        check("step_no_requeue", 32'(running), 32'h0);
        check("step_no_requeue_relays", 32'(relays), 32'h0);

        // Held step button: exactly one cycle
        exp_q.push_back(2'd2);
        single_step = 1'b1;
        tick(1);
        check("hold_running", 32'(running), 32'h1);
        tick(16);
        check("hold_end_relays", 32'(relays), 32'h0);
        tick(6);
        check("hold_no_retrigger", 32'(running), 32'h0);
        check("hold_count", 32'(cycle_count), 32'h2);
        single_step = 1'b0;
        tick(2);

        // Power drop at 0011, restart from 0000
        run_stop = 1'b1;
        tick(5);
        check("pwr_at_0011", 32'(relays), 32'h3);
        power = 1'b0;
        tick(1);
        check("pwr_relays", 32'(relays), 32'h0);
        check("pwr_running", 32'(running), 32'h0);
        check("pwr_cycle_done", 32'(cycle_done), 32'h0);
        check("pwr_count", 32'(cycle_count), 32'h2);
        tick(3);
        check("pwr_off_hold", 32'(relays), 32'h0);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        power = 1'b1;
        tick(2);
        check("pwr_restart_running", 32'(running), 32'h1);
        check("pwr_restart_relays", 32'(relays), 32'h0);
        tick(2);
        check("pwr_restart_step", 32'(relays), 32'h1);
        tick(46);
        check("wrap_count", 32'(cycle_count), 32'h1);
        run_stop = 1'b0;
        tick(1);
        check("stop_at_boundary", 32'(running), 32'h0);
        tick(4);
        check("stop_at_boundary_relays", 32'(relays), 32'h0);

        // Run and step edge on the same clock: RUN wins
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd3);
        run_stop    = 1'b1;
        single_step = 1'b1;
        tick(1);
        check("race_running", 32'(running), 32'h1);
        tick(32);
        check("race_continuous", 32'(running), 32'h1);
        check("race_count", 32'(cycle_count), 32'h3);
        run_stop    = 1'b0;
        single_step = 1'b0;
        tick(1);
        check("race_stop", 32'(running), 32'h0);

        // Asynchronous reset mid-cycle
        run_stop = 1'b1;
        tick(6);
        check("mid_rst_pre", 32'(relays), 32'h3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_relays", 32'(relays), 32'h0);
        check("mid_rst_count", 32'(cycle_count), 32'h0);
        check("mid_rst_running", 32'(running), 32'h0);
        run_stop = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(5);
        check("post_rst_running", 32'(running), 32'h0);
        check("post_rst_relays", 32'(relays), 32'h0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
